// File: rtl/regs_sb_if.sv
// rtl/regs_sb_if.sv - Debug (JTAG) request/acknowledge port bundle for regs_sb
// The debugger is the master; the register file is the slave.
interface regs_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            jtag_req_i;
  logic            jtag_we_i;
  logic [AW-1:0]   jtag_addr_i;
  logic [XLEN-1:0] jtag_data_i;
  logic            jtag_ack_o;
  logic [XLEN-1:0] jtag_data_o;

  modport master (
    output jtag_req_i, jtag_we_i, jtag_addr_i, jtag_data_i,
    input  jtag_ack_o, jtag_data_o
  );

  modport slave (
    input  jtag_req_i, jtag_we_i, jtag_addr_i, jtag_data_i,
    output jtag_ack_o, jtag_data_o
  );
endinterface

// File: rtl/regs_sb.sv
// rtl/regs_sb.sv - Register file with prioritised bypass, busy scoreboard and debug port
// Define REGS_SB_BYPASS_EN to enable EX/MEM forwarding; otherwise EX/MEM hits raise hazards.
module regs_sb #(
  parameter int  XLEN  = 32,
  parameter int  NREGS = 32,
  parameter int  NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic              ex_we_i,
  input  logic [AW-1:0]     ex_waddr_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_we_i,
  input  logic [AW-1:0]     mem_waddr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic              sb_set_i,
  input  logic [AW-1:0]     sb_rd_i,
  input  logic [NRD*AW-1:0] raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]    hazard_o,
  output logic              stall_o,
  regs_sb_if.slave          jtag
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             jtag_go;

  // Debug access only proceeds on edges where writeback leaves the array port free.
  assign jtag_go = !we_i && ((state == ST_IDLE && jtag.jtag_req_i) || state == ST_WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (jtag.jtag_req_i) state_nxt = we_i ? ST_WAIT : ST_ACK;
      ST_WAIT: if (!we_i) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      jtag.jtag_data_o <= '0;
    end else begin
      state <= state_nxt;
      if (jtag_go && !jtag.jtag_we_i) jtag.jtag_data_o <= regs[jtag.jtag_addr_i];
    end
  end

  assign jtag.jtag_ack_o = (state == ST_ACK);

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs[waddr_i] <= wdata_i;
    end else if (jtag_go && jtag.jtag_we_i && jtag.jtag_addr_i != '0) begin
      regs[jtag.jtag_addr_i] <= jtag.jtag_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (sb_set_i && sb_rd_i == AW'(r))      busy[r] <= 1'b1;
        else if (we_i && waddr_i == AW'(r))     busy[r] <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic            ex_hit;
    logic            mem_hit;
    logic            wb_hit;
    logic [XLEN-1:0] d;
    logic            hz;

    assign a       = raddr_i[p*AW +: AW];
    assign ex_hit  = ex_we_i  && ex_waddr_i  == a;
    assign mem_hit = mem_we_i && mem_waddr_i == a;
    assign wb_hit  = we_i     && waddr_i     == a;

    // Lower-priority sources are applied first so higher ones overwrite them.
    always_comb begin
      d  = regs[a];
      hz = 1'b0;
      if (wb_hit) d = wdata_i;
`ifdef REGS_SB_BYPASS_EN
      if (mem_hit) d = mem_wdata_i;
      if (ex_hit) begin
        if (ex_is_load_i) hz = 1'b1;
        else              d  = ex_wdata_i;
      end
`else
      if (ex_hit || mem_hit) hz = 1'b1;
`endif
      if (busy[a] && !wb_hit) hz = 1'b1;
      if (a == '0) begin
        d  = '0;
        hz = 1'b0;
      end
    end

    assign rdata_o[p*XLEN +: XLEN] = d;
    assign hazard_o[p]             = hz;
  end

  assign stall_o = |hazard_o;

`ifndef REGS_SB_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
`endif

endmodule

// File: tb/tb_regs_sb.sv
// tb/tb_regs_sb.sv - Self-checking bench for regs_sb: directed cases plus randomised traffic
// Honours REGS_SB_BYPASS_EN the same way the design does.
module tb_regs_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic              we_i;
  logic [AW-1:0]     waddr_i;
  logic [XLEN-1:0]   wdata_i;
  logic              ex_we_i;
  logic [AW-1:0]     ex_waddr_i;
  logic [XLEN-1:0]   ex_wdata_i;
  logic              ex_is_load_i;
  logic              mem_we_i;
  logic [AW-1:0]     mem_waddr_i;
  logic [XLEN-1:0]   mem_wdata_i;
  logic              sb_set_i;
  logic [AW-1:0]     sb_rd_i;
  logic [NRD*AW-1:0] raddr_i;
  logic [NRD*XLEN-1:0] rdata_o;
  logic [NRD-1:0]    hazard_o;
  logic              stall_o;

  regs_sb_if #(.XLEN(XLEN), .AW(AW)) jif ();

  regs_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .sb_set_i(sb_set_i), .sb_rd_i(sb_rd_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .hazard_o(hazard_o), .stall_o(stall_o),
    .jtag(jif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: architectural state and the debug transaction in flight.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_wait;
  bit              m_ack;
  logic [XLEN-1:0] m_jdata;

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_wait  = 1'b0;
    m_ack   = 1'b0;
    m_jdata = '0;
  endtask

  task automatic model_edge();
    bit access;
    access = 1'b0;
    if (m_ack) begin
      m_ack = 1'b0;
    end else if (jif.jtag_req_i || m_wait) begin
      if (we_i) m_wait = 1'b1;
      else begin
        access = 1'b1;
        m_wait = 1'b0;
        m_ack  = 1'b1;
      end
    end
    if (access) begin
      if (jif.jtag_we_i) begin
        if (jif.jtag_addr_i != 0) m_regs[jif.jtag_addr_i] = jif.jtag_data_i;
      end else begin
        m_jdata = m_regs[jif.jtag_addr_i];
      end
    end
    if (we_i) begin
      if (waddr_i != 0) m_regs[waddr_i] = wdata_i;
      m_busy[waddr_i] = 1'b0;
    end
    if (sb_set_i && sb_rd_i != 0) m_busy[sb_rd_i] = 1'b1;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_clear();
      else      model_edge();
    end
  end

  // Expected read value and hazard from the current model state and stage inputs.
  function automatic void exp_port(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic hz);
    bit ex_hit, mem_hit, wb_hit;
    ex_hit  = ex_we_i  && ex_waddr_i  == a;
    mem_hit = mem_we_i && mem_waddr_i == a;
    wb_hit  = we_i     && waddr_i     == a;
    if (a == 0) begin
      d  = '0;
      hz = 1'b0;
      return;
    end
    hz = m_busy[a] && !wb_hit;
`ifdef REGS_SB_BYPASS_EN
    if (ex_hit && ex_is_load_i) hz = 1'b1;
    if (ex_hit && !ex_is_load_i) d = ex_wdata_i;
    else if (mem_hit)            d = mem_wdata_i;
    else if (wb_hit)             d = wdata_i;
    else                         d = m_regs[a];
`else
    if (ex_hit || mem_hit) hz = 1'b1;
    d = wb_hit ? wdata_i : m_regs[a];
`endif
  endfunction

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      logic any_hz;
      any_hz = 1'b0;
      for (int p = 0; p < NRD; p++) begin
        logic [XLEN-1:0] ed;
        logic            eh;
        exp_port(raddr_i[p*AW +: AW], ed, eh);
        check($sformatf("model rdata%0d", p), rdata_o[p*XLEN +: XLEN], ed);
        check($sformatf("model hazard%0d", p), 32'(hazard_o[p]), 32'(eh));
        any_hz |= eh;
      end
      check("model stall", 32'(stall_o), 32'(any_hz));
      check("model jtag_ack", 32'(jif.jtag_ack_o), 32'(m_ack));
      check("model jtag_data", jif.jtag_data_o, m_jdata);
    end
  end

  task automatic idle_inputs();
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    ex_we_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
    mem_we_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;
    sb_set_i = 1'b0; sb_rd_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    raddr_i[p*AW +: AW] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  got;
    bit  pend;
    bit  ack_seen;
    idle_inputs();
    raddr_i = '0;
    jif.jtag_req_i = 1'b0; jif.jtag_we_i = 1'b0; jif.jtag_addr_i = '0; jif.jtag_data_i = '0;
    #2 rst = 1'b0;

    // Reset state
    set_rd(0, 5'd5);
    @(negedge clk);
    check("reset jtag_ack", 32'(jif.jtag_ack_o), 32'd0);
    check("reset jtag_data", jif.jtag_data_o, 32'd0);
    check("reset rdata0", rdata_o[31:0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
    next_cycle();

    for (int r = 0; r < NREGS; r++) begin
      set_rd(0, AW'(r));
      set_rd(1, AW'(NREGS - 1 - r));
      @(negedge clk);
      check("x0..x31 rdata", rdata_o, 64'd0);
      check("x0..x31 hazard", 32'(hazard_o), 32'd0);
      next_cycle();
    end

    // WB bypass then array
    we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF; set_rd(0, 5'd5);
    @(negedge clk);
    check("x5 wb bypass", rdata_o[31:0], 32'hDEADBEEF);
    next_cycle();
    we_i = 1'b0;
    @(negedge clk);
    check("x5 array", rdata_o[31:0], 32'hDEADBEEF);
    next_cycle();

    // EX/MEM/WB priority on x7
    ex_we_i = 1'b1; ex_waddr_i = 5'd7; ex_wdata_i = 32'h11;
    mem_we_i = 1'b1; mem_waddr_i = 5'd7; mem_wdata_i = 32'h22;
    we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'h33; set_rd(0, 5'd7);
    @(negedge clk);
`ifdef REGS_SB_BYPASS_EN
    check("x7 ex priority", rdata_o[31:0], 32'h11);
    check("x7 ex hazard", 32'(hazard_o[0]), 32'd0);
`else
    check("x7 nobypass data", rdata_o[31:0], 32'h33);
    check("x7 nobypass hazard", 32'(hazard_o[0]), 32'd1);
`endif
    next_cycle();
    ex_we_i = 1'b0;
    @(negedge clk);
`ifdef REGS_SB_BYPASS_EN
    check("x7 mem priority", rdata_o[31:0], 32'h22);
`else
    check("x7 nobypass mem hazard", 32'(hazard_o[0]), 32'd1);
`endif
    next_cycle();
    idle_inputs();

    // EX load hazard on x9
    ex_we_i = 1'b1; ex_waddr_i = 5'd9; ex_wdata_i = 32'h99; ex_is_load_i = 1'b1; set_rd(0, 5'd9);
    @(negedge clk);
    check("x9 load hazard", 32'(hazard_o[0]), 32'd1);
    check("x9 load stall", 32'(stall_o), 32'd1);
    next_cycle();
    ex_is_load_i = 1'b0;
    @(negedge clk);
`ifdef REGS_SB_BYPASS_EN
    check("x9 ex forward", rdata_o[31:0], 32'h99);
    check("x9 ex no hazard", 32'(hazard_o[0]), 32'd0);
`else
    check("x9 nobypass hazard", 32'(hazard_o[0]), 32'd1);
`endif
    next_cycle();
    idle_inputs();

    // Scoreboard on x12
    sb_set_i = 1'b1; sb_rd_i = 5'd12; set_rd(0, 5'd12);
    next_cycle();
    sb_set_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("x12 busy hazard", 32'(hazard_o[0]), 32'd1);
      next_cycle();
    end
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1234;
    @(negedge clk);
    check("x12 wb cycle hazard", 32'(hazard_o[0]), 32'd0);
    check("x12 wb cycle data", rdata_o[31:0], 32'h1234);
    next_cycle();
    we_i = 1'b0;
    @(negedge clk);
    check("x12 cleared hazard", 32'(hazard_o[0]), 32'd0);
    next_cycle();
    sb_set_i = 1'b1; sb_rd_i = 5'd12; we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h5678;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("x12 set wins", 32'(hazard_o[0]), 32'd1);
    next_cycle();
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h5678;
    next_cycle();
    idle_inputs();

    // JTAG write under 3 cycles of writeback contention
    jif.jtag_req_i = 1'b1; jif.jtag_we_i = 1'b1; jif.jtag_addr_i = 5'd3; jif.jtag_data_i = 32'hA5A5A5A5;
    we_i = 1'b1; waddr_i = 5'd20; wdata_i = 32'h2020;
    got = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (jif.jtag_ack_o) begin got = n; break; end
      next_cycle();
      if (n == 3) we_i = 1'b0;
    end
    check("jtag write ack cycle", 32'(got), 32'd5);
    next_cycle();
    jif.jtag_req_i = 1'b0; set_rd(1, 5'd3);
    @(negedge clk);
    check("jtag write x3 array", rdata_o[63:32], 32'hA5A5A5A5);
    next_cycle();

    // JTAG read
    jif.jtag_req_i = 1'b1; jif.jtag_we_i = 1'b0; jif.jtag_addr_i = 5'd3;
    got = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (jif.jtag_ack_o) begin got = n; break; end
      next_cycle();
    end
    check("jtag read ack cycle", 32'(got), 32'd2);
    check("jtag read data", jif.jtag_data_o, 32'hA5A5A5A5);
    next_cycle();
    jif.jtag_req_i = 1'b0;
    next_cycle();

    // Reset while waiting on writeback
    jif.jtag_req_i = 1'b1; jif.jtag_we_i = 1'b1; jif.jtag_addr_i = 5'd3; jif.jtag_data_i = 32'h12345678;
    we_i = 1'b1; waddr_i = 5'd21; wdata_i = 32'h21;
    next_cycle();
    next_cycle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset in wait ack", 32'(jif.jtag_ack_o), 32'd0);
    next_cycle();
    jif.jtag_req_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    set_rd(0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after reset ack", 32'(jif.jtag_ack_o), 32'd0);
      check("after reset x3", rdata_o[31:0], 32'd0);
      next_cycle();
    end

    // Randomised traffic against the model
    pend = 1'b0;
    ack_seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      we_i        = 1'($urandom_range(0, 1));
      waddr_i     = AW'($urandom_range(0, 7));
      wdata_i     = $urandom();
      ex_we_i     = 1'($urandom_range(0, 1));
      ex_waddr_i  = AW'($urandom_range(0, 7));
      ex_wdata_i  = $urandom();
      ex_is_load_i = 1'($urandom_range(0, 1));
      mem_we_i    = 1'($urandom_range(0, 1));
      mem_waddr_i = AW'($urandom_range(0, 7));
      mem_wdata_i = $urandom();
      sb_set_i    = ($urandom_range(0, 5) == 0);
      sb_rd_i     = AW'($urandom_range(0, 7));
      set_rd(0, AW'($urandom_range(0, 7)));
      set_rd(1, AW'($urandom_range(0, 7)));
      if (ack_seen) begin
        jif.jtag_req_i = 1'b0;
        pend = 1'b0;
      end
      if (!pend && $urandom_range(0, 3) == 0) begin
        jif.jtag_req_i  = 1'b1;
        jif.jtag_we_i   = 1'($urandom_range(0, 1));
        jif.jtag_addr_i = AW'($urandom_range(0, 7));
        jif.jtag_data_i = $urandom();
        pend = 1'b1;
      end
      @(negedge clk);
      ack_seen = jif.jtag_ack_o;
      next_cycle();
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
